// File: rtl/lc3b_types.sv
// Shared LC-3b memory-interface types and the state encoding for the
// instruction/data memory port arbiter.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    localparam lc3b_mem_wmask FULL_WMASK = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Free-running up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state is only ever assigned with <=, so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the pipeline's fetch and data memory ports onto one physical
// word port, with D priority, I anti-starvation and stall statistics.
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 i_mem_read,
    input  lc3b_word             i_mem_address,
    output lc3b_word             i_mem_rdata,
    output logic                 i_mem_resp,

    input  logic                 d_mem_read,
    input  logic                 d_mem_write,
    input  lc3b_word             d_mem_address,
    input  lc3b_word             d_mem_wdata,
    input  lc3b_mem_wmask        d_mem_byte_enable,
    output lc3b_word             d_mem_rdata,
    output logic                 d_mem_resp,

    output logic                 pmem_read,
    output logic                 pmem_write,
    output lc3b_word             pmem_address,
    output lc3b_word             pmem_wdata,
    output lc3b_mem_wmask        pmem_byte_enable,
    input  lc3b_word             pmem_rdata,
    input  logic                 pmem_resp,

    output logic [CNT_WIDTH-1:0] i_stall_count,
    output logic [CNT_WIDTH-1:0] d_stall_count
);

    localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state_q, state_d;
    logic                pmem_read_q, pmem_read_d;
    logic                pmem_write_q, pmem_write_d;
    lc3b_word            pmem_address_q, pmem_address_d;
    lc3b_word            pmem_wdata_q, pmem_wdata_d;
    lc3b_mem_wmask       pmem_byte_enable_q, pmem_byte_enable_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic i_req;
    logic d_req;
    logic i_forced;

    assign i_req    = i_mem_read;
    assign d_req    = d_mem_read | d_mem_write;
    // With the starve counter at its limit a pending fetch overrides D priority.
    assign i_forced = i_req && (starve_q == STARVE_MAX);

    always_comb begin
        state_d            = state_q;
        pmem_read_d        = pmem_read_q;
        pmem_write_d       = pmem_write_q;
        pmem_address_d     = pmem_address_q;
        pmem_wdata_d       = pmem_wdata_q;
        pmem_byte_enable_d = pmem_byte_enable_q;
        starve_d           = starve_q;

        unique case (state_q)
            IDLE: begin
                if (d_req && !i_forced) begin
                    state_d            = SERVE_D;
                    pmem_address_d     = d_mem_address;
                    pmem_wdata_d       = d_mem_wdata;
                    pmem_byte_enable_d = d_mem_byte_enable;
                    // Read and write together is a write.
                    pmem_write_d       = d_mem_write;
                    pmem_read_d        = ~d_mem_write;
                    if (i_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (i_req) begin
                    state_d            = SERVE_I;
                    pmem_address_d     = i_mem_address;
                    pmem_wdata_d       = '0;
                    pmem_byte_enable_d = FULL_WMASK;
                    pmem_write_d       = 1'b0;
                    pmem_read_d        = 1'b1;
                    starve_d           = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            pmem_read_q        <= 1'b0;
            pmem_write_q       <= 1'b0;
            pmem_address_q     <= '0;
            pmem_wdata_q       <= '0;
            pmem_byte_enable_q <= '0;
            starve_q           <= '0;
        end else begin
            state_q            <= state_d;
            pmem_read_q        <= pmem_read_d;
            pmem_write_q       <= pmem_write_d;
            pmem_address_q     <= pmem_address_d;
            pmem_wdata_q       <= pmem_wdata_d;
            pmem_byte_enable_q <= pmem_byte_enable_d;
            starve_q           <= starve_d;
        end
    end

    assign pmem_read        = pmem_read_q;
    assign pmem_write       = pmem_write_q;
    assign pmem_address     = pmem_address_q;
    assign pmem_wdata       = pmem_wdata_q;
    assign pmem_byte_enable = pmem_byte_enable_q;

    // Completion is combinational on pmem_resp; a stray pmem_resp in IDLE is dropped.
    assign i_mem_resp  = (state_q == SERVE_I) && pmem_resp;
    assign d_mem_resp  = (state_q == SERVE_D) && pmem_resp;
    assign i_mem_rdata = i_mem_resp ? pmem_rdata : '0;
    assign d_mem_rdata = d_mem_resp ? pmem_rdata : '0;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_i_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_req && !i_mem_resp),
        .count (i_stall_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_d_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (d_req && !d_mem_resp),
        .count (d_stall_count)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus queues expected completions,
// a negedge monitor pops and compares them against the DUT's resp pulses.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int CW = 4;

    typedef struct packed {
        logic        is_d;
        logic [15:0] rdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_mem_read;
    logic [15:0]   i_mem_address;
    logic [15:0]   i_mem_rdata;
    logic          i_mem_resp;
    logic          d_mem_read;
    logic          d_mem_write;
    logic [15:0]   d_mem_address;
    logic [15:0]   d_mem_wdata;
    logic [1:0]    d_mem_byte_enable;
    logic [15:0]   d_mem_rdata;
    logic          d_mem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [15:0]   pmem_address;
    logic [15:0]   pmem_wdata;
    logic [1:0]    pmem_byte_enable;
    logic [15:0]   pmem_rdata;
    logic          pmem_resp;
    logic [CW-1:0] i_stall_count;
    logic [CW-1:0] d_stall_count;

    // Memory model controls
    logic          mem_on;
    int            mem_delay;
    logic          man_resp;
    logic [15:0]   resp_data;
    int            wait_cnt;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_checks;
    int            n_fail;
    int            cyc;

    mem_port_arbiter #(.STARVE_LIMIT(3), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_mem_read        (i_mem_read),
        .i_mem_address     (i_mem_address),
        .i_mem_rdata       (i_mem_rdata),
        .i_mem_resp        (i_mem_resp),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_mem_address     (d_mem_address),
        .d_mem_wdata       (d_mem_wdata),
        .d_mem_byte_enable (d_mem_byte_enable),
        .d_mem_rdata       (d_mem_rdata),
        .d_mem_resp        (d_mem_resp),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_byte_enable  (pmem_byte_enable),
        .pmem_rdata        (pmem_rdata),
        .pmem_resp         (pmem_resp),
        .i_stall_count     (i_stall_count),
        .d_stall_count     (d_stall_count)
    );

    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic is_d, input logic [15:0] rdata);
        exp_t e;
        e.is_d  = is_d;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // Waits at negedges for any resp pulse; returns the cycle index it appeared in.
    task automatic wait_resp(input string name, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 64) begin
            @(negedge clk);
            if (i_mem_resp || d_mem_resp) begin
                at = cyc;
                break;
            end
            n++;
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no resp within 64 cycles", name);
        end
    endtask

    // Physical memory model: automatic responder after mem_delay strobe cycles, or manual pmem_resp.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        wait_cnt   = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!mem_on) begin
                pmem_resp  = man_resp;
                pmem_rdata = man_resp ? resp_data : 16'h0000;
                wait_cnt   = 0;
            end else begin
                pmem_resp  = 1'b0;
                pmem_rdata = 16'h0000;
                if (pmem_read || pmem_write) begin
                    if (wait_cnt >= mem_delay) begin
                        pmem_resp  = 1'b1;
                        pmem_rdata = resp_data;
                        wait_cnt   = 0;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    wait_cnt = 0;
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (i_mem_resp || d_mem_resp) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: i_resp=%0b d_resp=%0b with nothing outstanding", i_mem_resp, d_mem_resp);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("resp_port_is_d", {31'b0, d_mem_resp}, {31'b0, mon_e.is_d});
                    check("resp_other_port", {31'b0, mon_e.is_d ? i_mem_resp : d_mem_resp}, 32'd0);
                    check("resp_rdata", {16'b0, mon_e.is_d ? d_mem_rdata : i_mem_rdata}, {16'b0, mon_e.rdata});
                    check("other_port_rdata", {16'b0, mon_e.is_d ? i_mem_rdata : d_mem_rdata}, 32'd0);
                end
            end
        end
    end

    initial begin
        int at;
        int last;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        i_mem_read = 1'b0; i_mem_address = '0;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0;
        d_mem_wdata = '0; d_mem_byte_enable = '0;
        mem_on = 1'b1; mem_delay = 0; man_resp = 1'b0; resp_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
        check("rst_pmem_write", {31'b0, pmem_write}, 32'd0);
        check("rst_pmem_address", {16'b0, pmem_address}, 32'd0);
        check("rst_pmem_wdata", {16'b0, pmem_wdata}, 32'd0);
        check("rst_pmem_be", {30'b0, pmem_byte_enable}, 32'd0);
        check("rst_i_resp", {31'b0, i_mem_resp}, 32'd0);
        check("rst_d_resp", {31'b0, d_mem_resp}, 32'd0);
        check("rst_i_stall", {28'b0, i_stall_count}, 32'd0);
        check("rst_d_stall", {28'b0, d_stall_count}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single fetch, memory answers in the 4th strobe cycle
        i_mem_read = 1'b1; i_mem_address = 16'h0040;
        mem_delay = 3; resp_data = 16'h1234;
        push_exp(1'b0, 16'h1234);
        tick();
        check("fetch_pmem_read", {31'b0, pmem_read}, 32'd1);
        check("fetch_pmem_write", {31'b0, pmem_write}, 32'd0);
        check("fetch_pmem_address", {16'b0, pmem_address}, 32'h0040);
        check("fetch_pmem_be", {30'b0, pmem_byte_enable}, 32'd3);
        wait_resp("fetch_resp", at);
        tick();
        i_mem_read = 1'b0;
        check("fetch_i_stall", {28'b0, i_stall_count}, 32'd4);
        @(negedge clk);
        check("fetch_resp_one_cycle", {31'b0, i_mem_resp}, 32'd0);

        // Masked write
        tick();
        d_mem_write = 1'b1; d_mem_address = 16'h0102;
        d_mem_wdata = 16'hABCD; d_mem_byte_enable = 2'b01;
        mem_delay = 0; resp_data = 16'h0BAD;
        push_exp(1'b1, 16'h0BAD);
        tick();
        check("wr_pmem_write", {31'b0, pmem_write}, 32'd1);
        check("wr_pmem_read", {31'b0, pmem_read}, 32'd0);
        check("wr_pmem_be", {30'b0, pmem_byte_enable}, 32'd1);
        check("wr_pmem_wdata", {16'b0, pmem_wdata}, 32'hABCD);
        check("wr_pmem_address", {16'b0, pmem_address}, 32'h0102);
        wait_resp("wr_resp", at);
        check("wr_no_i_resp", {31'b0, i_mem_resp}, 32'd0);
        tick();
        d_mem_write = 1'b0;
        check("wr_d_stall", {28'b0, d_stall_count}, 32'd1);

        // Read and write together is a write
        d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_address = 16'h0200;
        d_mem_wdata = 16'h1111; d_mem_byte_enable = 2'b11; resp_data = 16'h0C0C;
        push_exp(1'b1, 16'h0C0C);
        tick();
        check("rw_pmem_write", {31'b0, pmem_write}, 32'd1);
        check("rw_pmem_read", {31'b0, pmem_read}, 32'd0);
        check("rw_pmem_address", {16'b0, pmem_address}, 32'h0200);
        wait_resp("rw_resp", at);
        tick();
        d_mem_read = 1'b0; d_mem_write = 1'b0;
        check("rw_d_stall", {28'b0, d_stall_count}, 32'd2);

        // Continuous conflict: D,D,D,I,D,D,D,I with one IDLE cycle between grants
        i_mem_read = 1'b1; i_mem_address = 16'h0300;
        d_mem_read = 1'b1; d_mem_address = 16'h0400; d_mem_byte_enable = 2'b11;
        resp_data = 16'h5A5A;
        for (int k = 0; k < 8; k++) push_exp((k % 4) != 3, 16'h5A5A);
        last = -1;
        for (int k = 0; k < 8; k++) begin
            wait_resp("conflict_resp", at);
            if (k > 0 && at >= 0 && last >= 0) check("conflict_gap", at - last, 32'd2);
            last = at;
        end
        tick();
        i_mem_read = 1'b0; d_mem_read = 1'b0;
        tick();

        // Reset during SERVE_I, then a late pmem_resp
        mem_on = 1'b0; man_resp = 1'b0;
        i_mem_read = 1'b1; i_mem_address = 16'h0500;
        tick();
        check("rstmid_pmem_read", {31'b0, pmem_read}, 32'd1);
        #1;
        rst_n = 1'b0;
        i_mem_read = 1'b0;
        #1;
        check("rstmid_async_drop", {31'b0, pmem_read}, 32'd0);
        check("rstmid_addr_clear", {16'b0, pmem_address}, 32'd0);
        check("rstmid_i_stall", {28'b0, i_stall_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        resp_data = 16'hDEAD;
        man_resp = 1'b1;
        @(negedge clk);
        check("late_resp_ignored", {31'b0, i_mem_resp}, 32'd0);
        tick();
        man_resp = 1'b0;
        check("late_resp_idle_read", {31'b0, pmem_read}, 32'd0);
        check("late_resp_idle_write", {31'b0, pmem_write}, 32'd0);

        // Stall counter saturation at 4'hF
        i_mem_read = 1'b1; i_mem_address = 16'h0600;
        repeat (20) tick();
        check("sat_i_stall", {28'b0, i_stall_count}, 32'd15);
        repeat (3) tick();
        check("sat_i_stall_hold", {28'b0, i_stall_count}, 32'd15);
        resp_data = 16'h7777;
        push_exp(1'b0, 16'h7777);
        man_resp = 1'b1;
        wait_resp("sat_resp", at);
        tick();
        man_resp = 1'b0;
        i_mem_read = 1'b0;
        check("sat_i_stall_after", {28'b0, i_stall_count}, 32'd15);

        repeat (2) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
